tank_addr_latch_r1_up: RTL
==========================

Name: tank_addr_latch_r1_up

Overview:
Serial-to-parallel address capture stage that sits directly upstream of the r1 upper-bank tank decoder.
- Samples the order word arriving serially from the order tank, one digit per clock, aligned to the minor-cycle sync pulse.
- Latches address digits f7 and f8 and presents them to the decoder as dual-rail pairs.
- Generates the tank-in or tank-out gating window for exactly one transfer minor cycle.

Parameters:
DIGITS, 18, digit positions per minor cycle (17 bits + gap)
F7_POS, 7, digit position of address bit f7
F8_POS, 8, digit position of address bit f8
BANK_POS, 9, digit position of bank-select bit (used only with the optional feature)
BANK_VALUE, 1, bank-select value that qualifies the r1 upper bank (used only with the optional feature)

Ports:
clk  input  1  system clock, one digit per cycle
rst_n  input  1  asynchronous active-low reset
dp_sync  input  1  one-cycle pulse marking digit 0 of a minor cycle
order_bit  input  1  serial order digit, LSB first, valid every cycle
start  input  1  one-cycle request to capture the next order word
dir  input  1  transfer direction, sampled with start: 1 = store write (t_in), 0 = store read (t_out)
r1_up_f7_pos  output  1  f7 = 1 rail
r1_up_f7_neg  output  1  f7 = 0 rail
r1_up_f8_pos  output  1  f8 = 1 rail
r1_up_f8_neg  output  1  f8 = 0 rail
r1_up_t_in  output  1  tank-in gating window
r1_up_t_out  output  1  tank-out gating window
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on transfer completion
sync_err  output  1  one-cycle pulse on misaligned dp_sync

Behaviour:
- Reset: all outputs 0, state IDLE, digit counter 0, latched bits 0, dir latch 0. Reset is asynchronous, active-low, and may assert at any point; it aborts any operation immediately.
- Digit counter dcnt, width clog2(DIGITS):
  - Loads 0 on the cycle dp_sync is high.
  - Otherwise increments, wrapping DIGITS-1 -> 0.
  - Free-runs in all states.
- State machine:
  - IDLE: start = 1 latches dir and goes to ARM.
  - ARM: waits for dp_sync. On the dp_sync cycle, samples order_bit as digit 0 and goes to CAPTURE.
  - CAPTURE: samples order_bit each cycle. At dcnt == F7_POS, latches f7; at dcnt == F8_POS, latches f8. When dcnt == DIGITS-1, goes to WAIT.
  - WAIT: sets the rails valid and waits for dp_sync. On dp_sync, goes to XFER.
  - XFER: lasts exactly DIGITS cycles, starting with the dp_sync cycle. Leaves on the cycle with dcnt == DIGITS-1 and goes to DONE.
  - DONE: done = 1 for one cycle, rails return to neutral, next state IDLE.
- Dual-rail outputs are registered:
  - Valid from WAIT through XFER: pos = bit, neg = ~bit.
  - All other states: both rails 0 (neutral, no tank selected).
  - pos and neg are never both 1.
- r1_up_t_in = (state == XFER) & dir; r1_up_t_out = (state == XFER) & ~dir. Both are registered so they align with the rails. They are never both 1.
- start while busy is ignored; dir changes while busy are ignored.
- dp_sync in CAPTURE with dcnt != 0 (early resync):
  - sync_err pulses for one cycle.
  - State returns to IDLE and rails go neutral.
  - No done pulse.
- Latency from start (with dp_sync already due) is deterministic: rails valid DIGITS cycles after the ARM->CAPTURE sync, and done exactly DIGITS cycles after the XFER entry sync.

Optional Feature:
Macro TANK_R1_UP_BANK_QUALIFY_EN.
- Defined:
  - Latches the order digit at BANK_POS during CAPTURE.
  - If it differs from BANK_VALUE, WAIT and XFER are skipped: state goes straight to IDLE after CAPTURE, rails stay neutral, t_in and t_out stay 0, and there is no done pulse.
  - Adds output port bank_miss (1 bit), a one-cycle pulse on the cycle CAPTURE exits.
- Undefined: no bank check, no bank_miss port; every capture proceeds to XFER.

Test Plan:
- Reset mid-XFER: assert rst_n = 0 while t_in = 1 -> all outputs 0 in the same cycle; after release, busy = 0 and start accepted.
- Write transfer: DIGITS = 18, order word with digit7 = 1, digit8 = 0, dir = 1, start then dp_sync -> 18 cycles later f7_pos = 1, f7_neg = 0, f8_pos = 0, f8_neg = 1; at the next dp_sync t_in = 1 for exactly 18 cycles, t_out = 0; done pulses once.
- Read transfer: digit7 = 0, digit8 = 1, dir = 0 -> f7_neg = 1, f8_pos = 1, t_out high 18 cycles, t_in never high.
- Early resync: dp_sync reasserted at dcnt = 5 during CAPTURE -> sync_err = 1 for one cycle, state IDLE, all rails 0, no done.
- Busy rejection: second start with dir = 0 during XFER of a dir = 1 transfer -> t_in window unchanged at 18 cycles, exactly one done, no t_out.
- With TANK_R1_UP_BANK_QUALIFY_EN: digit9 = 0 -> bank_miss = 1 for one cycle, no rails, no t_in or t_out, no done. Repeating with digit9 = 1 -> normal transfer.

Source files
------------

// File: rtl/tank_addr_latch_r1_up.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tank_addr_latch_r1_up                                           |
// | Purpose  : Serial order-word capture of f7/f8 into dual-rail pairs for the  |
// |            r1 upper-bank tank decoder, plus one-minor-cycle t_in/t_out.     |
// | Option   : TANK_R1_UP_BANK_QUALIFY_EN adds a bank-select check + bank_miss. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tank_addr_latch_r1_up #(
  parameter int DIGITS = 18,
  parameter int F7_POS = 7,
  parameter int F8_POS = 8
`ifdef TANK_R1_UP_BANK_QUALIFY_EN
  ,
  parameter int   BANK_POS   = 9,
  parameter logic BANK_VALUE = 1'b1
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dp_sync,
  input  logic order_bit,
  input  logic start,
  input  logic dir,
  output logic r1_up_f7_pos,
  output logic r1_up_f7_neg,
  output logic r1_up_f8_pos,
  output logic r1_up_f8_neg,
  output logic r1_up_t_in,
  output logic r1_up_t_out,
  output logic busy,
  output logic done,
  output logic sync_err
`ifdef TANK_R1_UP_BANK_QUALIFY_EN
  ,
  output logic bank_miss
`endif
);

  localparam int              CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(DIGITS - 1);
  localparam logic [CW-1:0]   C_F7   = CW'(F7_POS);
  localparam logic [CW-1:0]   C_F8   = CW'(F8_POS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_WAIT    = 3'd3,
    S_XFER    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] xcnt_q, xcnt_d;
  logic [CW-1:0] w_dpos;
  logic          f7_q, f7_d, f8_q, f8_d, dir_q, dir_d;
  logic          w_sample, w_resync, w_sync_err, w_rails, w_xfer;
  logic          f7_pos_q, f7_neg_q, f8_pos_q, f8_neg_q;
  logic          t_in_q, t_out_q, busy_q, done_q, sync_err_q;
`ifdef TANK_R1_UP_BANK_QUALIFY_EN
  localparam logic [CW-1:0]   C_BANK = CW'(BANK_POS);
  logic          bank_q, bank_d, miss_q, w_bank_miss;
`endif

  always_comb begin
    // w_dpos is the digit position of the current cycle; dp_sync forces it to 0.
    w_dpos     = dp_sync ? '0 : dcnt_q;
    dcnt_d     = (w_dpos == C_LAST) ? '0 : w_dpos + 1'b1;
    w_resync   = dp_sync && (dcnt_q != '0);
    state_d    = state_q;
    xcnt_d     = xcnt_q;
    dir_d      = dir_q;
    w_sample   = 1'b0;
    w_sync_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d   = dir;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (dp_sync) begin
          w_sample = 1'b1;
          state_d  = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (w_resync) begin
          w_sync_err = 1'b1;
          state_d    = S_IDLE;
        end else begin
          w_sample = 1'b1;
          if (w_dpos == C_LAST) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dp_sync) begin
          xcnt_d  = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (xcnt_q == C_LAST) state_d = S_DONE;
        else                  xcnt_d  = xcnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    f7_d = (w_sample && (w_dpos == C_F7)) ? order_bit : f7_q;
    f8_d = (w_sample && (w_dpos == C_F8)) ? order_bit : f8_q;

`ifdef TANK_R1_UP_BANK_QUALIFY_EN
    bank_d      = (w_sample && (w_dpos == C_BANK)) ? order_bit : bank_q;
    w_bank_miss = 1'b0;
    if ((state_q == S_CAPTURE) && (state_d == S_WAIT) && (bank_d != BANK_VALUE)) begin
      w_bank_miss = 1'b1;
      state_d     = S_IDLE;
    end
`endif

    w_rails = (state_d == S_WAIT) || (state_d == S_XFER);
    w_xfer  = (state_d == S_XFER);
  end

  // Outputs are registered from the next state so rails and gates change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dcnt_q     <= '0;
      xcnt_q     <= '0;
      f7_q       <= 1'b0;
      f8_q       <= 1'b0;
      dir_q      <= 1'b0;
      f7_pos_q   <= 1'b0;
      f7_neg_q   <= 1'b0;
      f8_pos_q   <= 1'b0;
      f8_neg_q   <= 1'b0;
      t_in_q     <= 1'b0;
      t_out_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sync_err_q <= 1'b0;
`ifdef TANK_R1_UP_BANK_QUALIFY_EN
      bank_q     <= 1'b0;
      miss_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      xcnt_q     <= xcnt_d;
      f7_q       <= f7_d;
      f8_q       <= f8_d;
      dir_q      <= dir_d;
      f7_pos_q   <= w_rails &  f7_d;
      f7_neg_q   <= w_rails & ~f7_d;
      f8_pos_q   <= w_rails &  f8_d;
      f8_neg_q   <= w_rails & ~f8_d;
      t_in_q     <= w_xfer &  dir_d;
      t_out_q    <= w_xfer & ~dir_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      sync_err_q <= w_sync_err;
`ifdef TANK_R1_UP_BANK_QUALIFY_EN
      bank_q     <= bank_d;
      miss_q     <= w_bank_miss;
`endif
    end
  end

  assign r1_up_f7_pos = f7_pos_q;
  assign r1_up_f7_neg = f7_neg_q;
  assign r1_up_f8_pos = f8_pos_q;
  assign r1_up_f8_neg = f8_neg_q;
  assign r1_up_t_in   = t_in_q;
  assign r1_up_t_out  = t_out_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sync_err     = sync_err_q;
`ifdef TANK_R1_UP_BANK_QUALIFY_EN
  assign bank_miss    = miss_q;
`endif

endmodule
`default_nettype wire
